gpio_frontend_wrapper: RTL and testbench

//  Parametrised GPIO front end between the breakout-board pins and a user design.

---
 rtl/gpio_frontend_wrapper.sv | 134 +++++++++++++
 tb/tb_gpio_frontend_wrapper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_frontend_wrapper.sv
// rtl/gpio_frontend_wrapper.sv - GPIO front end: pushbutton sync/debounce, pad output registering, chip-select gated enable
module gpio_frontend_wrapper #(
  parameter int GPIO_W          = 34,
  parameter int NUM_PB          = 10,
  parameter int OUT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ncs,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oeb,
  input  logic [OUT_W-1:0]  design_out,
  output logic              design_en,
  output logic [NUM_PB-1:0] pb_clean,
  output logic [NUM_PB-1:0] pb_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if ((NUM_PB + OUT_W > GPIO_W) || (DEBOUNCE_CYCLES < 2)) begin : g_bad_params
      $error("gpio_frontend_wrapper: NUM_PB+OUT_W must fit in GPIO_W and DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  state_t                     state, state_next;
  logic [CW-1:0]              arm_cnt, arm_cnt_next;
  logic                       ncs_meta, ncs_sync;
  logic [NUM_PB-1:0]          pb_meta, pb_sync;
  logic [NUM_PB-1:0]          stable, stable_next;
  logic [NUM_PB-1:0][CW-1:0]  cnt, cnt_next;
  logic [OUT_W-1:0]           out_q;
  logic                       unused_pads;

  // Pads above the pushbutton field are inputs nobody reads.
  assign unused_pads = ^gpio_in[GPIO_W-1:NUM_PB];

  // Two-flop synchronisers; ncs idles deselected (1), buttons idle released (0).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ncs_meta <= 1'b1;
      ncs_sync <= 1'b1;
      pb_meta  <= '0;
      pb_sync  <= '0;
    end else begin
      ncs_meta <= ncs;
      ncs_sync <= ncs_meta;
      pb_meta  <= gpio_in[NUM_PB-1:0];
      pb_sync  <= pb_meta;
    end
  end

  // Per-button debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_next = stable;
    cnt_next    = cnt;
    for (int i = 0; i < NUM_PB; i++) begin
      if (pb_sync[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_next[i] = pb_sync[i];
        cnt_next[i]    = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Chip-select FSM: ARM holds off enabling until ncs has stayed low long enough.
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    case (state)
      IDLE: begin
        if (!ncs_sync) begin
          state_next   = ARM;
          arm_cnt_next = '0;
        end
      end
      ARM: begin
        if (ncs_sync) begin
          state_next = IDLE;
        end else if (arm_cnt == CNT_MAX) begin
          state_next = ACTIVE;
        end else begin
          arm_cnt_next = arm_cnt + CW'(1);
        end
      end
      ACTIVE: begin
        if (ncs_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, debounce and registered pad/strobe outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      arm_cnt <= '0;
      stable  <= '0;
      cnt     <= '0;
      pb_rise <= '0;
      out_q   <= '0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
      stable  <= stable_next;
      cnt     <= cnt_next;
      // Strobe only when ACTIVE on both sides of the edge, so buttons held through ARM
      // and edges that coincide with deselect never strobe.
      pb_rise <= stable_next & ~stable &
                 {NUM_PB{(state == ACTIVE) && (state_next == ACTIVE)}};
      out_q   <= (state == ACTIVE) ? design_out : '0;
    end
  end

  assign design_en = (state == ACTIVE);
  assign pb_clean  = stable & {NUM_PB{design_en}};

  // Only the design output field is ever driven; everything else stays an undriven zero.
  always_comb begin
    gpio_out                     = '0;
    gpio_out[NUM_PB +: OUT_W]    = out_q;
    gpio_oeb                     = '1;
    gpio_oeb[NUM_PB +: OUT_W]    = {OUT_W{~design_en}};
  end

endmodule

// File: tb/tb_gpio_frontend_wrapper.sv
// tb/tb_gpio_frontend_wrapper.sv - self-checking bench for gpio_frontend_wrapper
module tb_gpio_frontend_wrapper;

  localparam int DEB  = 4;
  localparam int MAXE = 4096;
  localparam logic [33:0] ALL1    = {34{1'b1}};
  localparam logic [33:0] ACT_OEB = 34'h3_FC00_03FF;

  logic        clk;
  logic        n_rst;
  logic        ncs;
  logic [33:0] gpio_in;
  logic [33:0] gpio_out;
  logic [33:0] gpio_oeb;
  logic [15:0] design_out;
  logic        design_en;
  logic [9:0]  pb_clean;
  logic [9:0]  pb_rise;

  int checks;
  int errors;

  // Reference model: edges counted from reset release, pad histories per edge.
  int          e;
  int          zrun;
  bit          m_active;
  logic [9:0]  m_stable;
  logic [9:0]  m_rise;
  logic [15:0] m_out;
  logic        ncs_h [MAXE];
  logic [9:0]  pb_h [MAXE];
  int          rise_seen [10];

  gpio_frontend_wrapper dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .ncs        (ncs),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oeb   (gpio_oeb),
    .design_out (design_out),
    .design_en  (design_en),
    .pb_clean   (pb_clean),
    .pb_rise    (pb_rise)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e        = 0;
    zrun     = 0;
    m_active = 1'b0;
    m_stable = '0;
    m_rise   = '0;
    m_out    = '0;
  endtask

  // Button level as seen after the two-stage synchroniser at edge idx.
  function automatic logic syncpb(input int idx, input int b);
    return (idx >= 2) ? pb_h[idx-2][b] : 1'b0;
  endfunction

  // Enabled once the synced select has been low for DEB+1 consecutive edges; a button
  // level is accepted once the last DEB synced samples all agree on a new value.
  task automatic model_edge(input logic [15:0] d);
    logic       z;
    bit         act_b;
    logic [9:0] ns;
    logic       v;
    bit         all;
    z     = (e >= 2) ? ncs_h[e-2] : 1'b1;
    act_b = m_active;
    zrun  = z ? 0 : zrun + 1;
    m_active = (zrun >= DEB + 1);
    for (int b = 0; b < 10; b++) begin
      v   = syncpb(e, b);
      all = 1'b1;
      for (int k = 1; k < DEB; k++) if (syncpb(e - k, b) !== v) all = 1'b0;
      ns[b] = (all && (v !== m_stable[b])) ? v : m_stable[b];
    end
    m_rise   = ns & ~m_stable & {10{act_b && m_active}};
    m_stable = ns;
    m_out    = act_b ? d : 16'h0;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input logic ncs_v, input logic [9:0] pb_v, input logic [15:0] d_v);
    ncs            = ncs_v;
    gpio_in[33:10] = 24'($urandom);
    gpio_in[9:0]   = pb_v;
    design_out     = d_v;
    ncs_h[e]       = ncs_v;
    pb_h[e]        = pb_v;
    @(posedge clk);
    model_edge(d_v);
    e++;
    @(negedge clk);
    chk("design_en", 64'(design_en), 64'(m_active));
    chk("gpio_oeb", 64'(gpio_oeb), 64'(m_active ? ACT_OEB : ALL1));
    chk("gpio_out", 64'(gpio_out), 64'({8'h0, m_out, 10'h0}));
    chk("pb_clean", 64'(pb_clean), 64'(m_stable & {10{m_active}}));
    chk("pb_rise", 64'(pb_rise), 64'(m_rise));
    for (int b = 0; b < 10; b++) if (pb_rise[b]) rise_seen[b]++;
  endtask

  initial begin
    logic       ncs_r;
    logic [9:0] pb_r;
    checks = 0;
    errors = 0;
    for (int b = 0; b < 10; b++) rise_seen[b] = 0;
    n_rst      = 1'b0;
    ncs        = 1'b1;
    gpio_in    = '0;
    design_out = '0;
    model_reset();

    @(negedge clk);
    chk("rst_oeb", 64'(gpio_oeb), 64'(ALL1));
    chk("rst_out", 64'(gpio_out), 64'h0);
    chk("rst_en", 64'(design_en), 64'h0);
    chk("rst_clean", 64'(pb_clean), 64'h0);
    chk("rst_rise", 64'(pb_rise), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Button 3 held while deselected, then select falls.
    for (int k = 0; k < 4; k++) step(1'b1, 10'h008, 16'h0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 10'h008, 16'h0);
      if (k == 6) chk("t2_en_edge6", 64'(design_en), 64'h0);
      if (k == 7) begin
        chk("t2_en_edge7", 64'(design_en), 64'h1);
        chk("t2_oeb", 64'(gpio_oeb), 64'(ACT_OEB));
        chk("t4_clean3", 64'(pb_clean[3]), 64'h1);
      end
    end
    for (int k = 0; k < 8; k++) step(1'b0, 10'h000, 16'h0);
    chk("t4_no_rise3", 64'(rise_seen[3]), 64'h0);

    // Design data appears one edge after it is presented.
    step(1'b0, 10'h000, 16'hA5C3);
    chk("t5_out", 64'(gpio_out[25:10]), 64'hA5C3);

    // Short pulse dropped, long press gives one strobe.
    rise_seen[0] = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 10'h001, 16'hA5C3);
    for (int k = 0; k < 8; k++) step(1'b0, 10'h000, 16'hA5C3);
    chk("t3_short_clean", 64'(pb_clean[0]), 64'h0);
    chk("t3_short_rise", 64'(rise_seen[0]), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 10'h001, 16'hA5C3);
      if (k == 5) chk("t3_clean_edge5", 64'(pb_clean[0]), 64'h0);
      if (k == 6) chk("t3_clean_edge6", 64'(pb_clean[0]), 64'h1);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 10'h001, 16'hA5C3);
    chk("t3_one_rise", 64'(rise_seen[0]), 64'h1);

    // Deselect releases the pads.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 10'h001, 16'hA5C3);
      if (k == 2) chk("t5_oeb_edge2", 64'(gpio_oeb), 64'(ACT_OEB));
      if (k == 3) begin
        chk("t5_oeb_edge3", 64'(gpio_oeb), 64'(ALL1));
        chk("t5_out_edge3", 64'(gpio_out[25:10]), 64'hA5C3);
      end
      if (k == 4) chk("t5_out_edge4", 64'(gpio_out[25:10]), 64'h0);
    end

    // Reselect, then deselect on the edge button 1 becomes stable.
    for (int k = 0; k < 8; k++) step(1'b0, 10'h000, 16'h0);
    chk("t6_active", 64'(design_en), 64'h1);
    rise_seen[1] = 0;
    for (int k = 0; k < 10; k++) step((k >= 3) ? 1'b1 : 1'b0, 10'h002, 16'h0);
    chk("t6_no_rise1", 64'(rise_seen[1]), 64'h0);
    chk("t6_idle", 64'(design_en), 64'h0);

    // Randomised traffic against the model.
    ncs_r = 1'b0;
    pb_r  = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 29) == 0) ncs_r = ~ncs_r;
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 5) == 0) pb_r[b] = ~pb_r[b];
      step(ncs_r, pb_r, 16'($urandom));
    end

    // Asynchronous reset mid-ACTIVE.
    for (int k = 0; k < 8; k++) step(1'b0, 10'h000, 16'h1234);
    chk("t1_pre_en", 64'(design_en), 64'h1);
    chk("t1_pre_out", 64'(gpio_out[25:10]), 64'h1234);
    #2 n_rst = 1'b0;
    #1;
    chk("t1_oeb", 64'(gpio_oeb), 64'(ALL1));
    chk("t1_out", 64'(gpio_out), 64'h0);
    chk("t1_en", 64'(design_en), 64'h0);
    chk("t1_clean", 64'(pb_clean), 64'h0);
    chk("t1_rise", 64'(pb_rise), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
